memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Fourth pipeline stage (MEM) of the 5-stage MIPS; directly downstream of the execute stage.
- Consumes the EX/MEM values: ALU result, store data, branch target, zero flag, destination register and control buses.
- Performs byte/half/word loads and stores on an internal synchronous data memory and resolves the branch decision for fetch.
- Registers the MEM/WB pipeline register and exposes a second read port for the debug unit.

Parameters:
- len, 32, datapath width.
- NB, $clog2(len), register-index width.
- ADDR_W, 10, data memory word-address width (depth 2^ADDR_W words).
- len_mem_bus, 9, memory control bus width.
- len_wb_bus, 2, writeback control bus width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  pipeline step enable from the debug unit; 0 freezes the stage.
- in_pc_branch  in  len  branch target computed in EX.
- in_alu  in  len  ALU result; byte address for loads/stores.
- in_zero_flag  in  1  ALU zero flag.
- in_reg2  in  len  store data (rt).
- in_write_reg  in  NB  destination register.
- memory_bus  in  len_mem_bus  [0] beq, [1] bne, [2] mem_read, [3] mem_write, [5:4] size (00 byte, 01 half, 11 word, 10 reserved = word), [6] unsigned load, [8:7] reserved.
- writeBack_bus  in  len_wb_bus  [0] reg_write, [1] mem_to_reg; passed through.
- debug_addr  in  ADDR_W  debug word address.
- out_pc_src  out  1  combinational branch taken.
- out_pc_branch  out  len  combinational pass-through of in_pc_branch to fetch.
- out_read_data  out  len  load result, extended.
- out_alu  out  len  registered ALU result.
- out_write_reg  out  NB  registered destination.
- writeBack_bus_out  out  len_wb_bus  registered writeback controls.
- debug_data  out  len  registered word at debug_addr.
- misalign_error  out  1  sticky misaligned-access flag.
- misalign_addr  out  len  address of the first misaligned access.

Behaviour:
- Branch decision: out_pc_src = (beq & in_zero_flag) | (bne & ~in_zero_flag). Purely combinational; not gated by enable.
- Addressing: word index = in_alu[ADDR_W+1:2]; upper bits are ignored, so addresses wrap. Byte offset = in_alu[1:0]. Byte order is little-endian (offset 0 = bits [7:0]).
- Misalignment: half access with in_alu[0]=1, or word access with in_alu[1:0]!=0, is misaligned; this applies when mem_read or mem_write is set.
  - A misaligned store writes nothing.
  - A misaligned load yields out_read_data=0.
  - misalign_error sets and stays set until reset.
  - misalign_addr captures in_alu only on the first occurrence; later misaligned accesses do not update it.
- Stores, when enable=1 and mem_write=1 and aligned:
  - byte: byte lane in_alu[1:0] ← in_reg2[7:0].
  - half: lanes {1,0} or {3,2} ← in_reg2[15:0].
  - word: full write.
  - Unselected lanes are preserved. Write takes effect at the clock edge.
- Loads: memory read is synchronous. The word, byte offset, size, unsigned bit and misalign status are registered together. out_read_data is extracted combinationally from those registers.
  - Byte/half results are sign-extended, or zero-extended when the unsigned bit is set.
  - When mem_read=0 in the captured cycle, out_read_data=0.
- Latency: 1 cycle. out_read_data, out_alu, out_write_reg and writeBack_bus_out are all valid in the cycle after the instruction is presented. They remain mutually aligned for the WB mux and the forwarding path.
- Simultaneous mem_read and mem_write: not produced by decode. The store is performed and the read returns the pre-write word (read-first).
- enable=0:
  - No memory write.
  - MEM/WB registers, misalign state and extraction registers hold.
  - debug_data still updates every cycle.
- reset (synchronous; wins over enable):
  - out_alu, out_write_reg, writeBack_bus_out, debug_data, misalign_addr, misalign_error and the extraction registers clear to 0, so out_read_data=0.
  - A store presented in the reset cycle is suppressed.
  - Memory contents are not cleared.
- Debug port: debug_data ← mem[debug_addr] every cycle, read-first relative to a same-cycle store.

Test Plan:
- Word store/load: sw 0xDEADBEEF @0x10, then lw @0x10 → out_read_data=0xDEADBEEF one cycle after the lw; debug_addr=4 → debug_data=0xDEADBEEF.
- Byte/half extension: after the word store above, lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD; lhu @0x10 → 0x0000BEEF.
- Partial stores: sb 0x55 @0x11, then lw @0x10 → 0xDEAD55EF; sh 0x1234 @0x12 → lw gives 0x123455EF.
- Misalignment: sw @0x21 → memory unchanged, misalign_error=1, misalign_addr=0x21; then lh @0x33 → out_read_data=0, misalign_addr stays 0x21; reset → both cleared.
- Branch: beq with zero=1 → out_pc_src=1; beq with zero=0 → 0; bne with zero=0 → 1; out_pc_branch tracks in_pc_branch in the same cycle.
- Freeze and reset: enable=0 with sw 0x1 @0x40 → no write, outputs held; reset asserted with sw @0x44 → store suppressed, outputs 0, earlier contents @0x10 still readable.

Source files
------------

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MIPS MEM stage: data memory, load/store sizing, branch resolve, MEM/WB register.
module memory_access #(
  parameter int len         = 32,
  parameter int NB          = $clog2(len),
  parameter int ADDR_W      = 10,
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [len-1:0]         in_pc_branch,
  input  logic [len-1:0]         in_alu,
  input  logic                   in_zero_flag,
  input  logic [len-1:0]         in_reg2,
  input  logic [NB-1:0]          in_write_reg,
  input  logic [len_mem_bus-1:0] memory_bus,
  input  logic [len_wb_bus-1:0]  writeBack_bus,
  input  logic [ADDR_W-1:0]      debug_addr,
  output logic                   out_pc_src,
  output logic [len-1:0]         out_pc_branch,
  output logic [len-1:0]         out_read_data,
  output logic [len-1:0]         out_alu,
  output logic [NB-1:0]          out_write_reg,
  output logic [len_wb_bus-1:0]  writeBack_bus_out,
  output logic [len-1:0]         debug_data,
  output logic                   misalign_error,
  output logic [len-1:0]         misalign_addr
);

  logic [len-1:0]    r_mem [0:(2**ADDR_W)-1];
  logic [len-1:0]    r_rd_word;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_rd_en;
  logic [len-1:0]    r_alu;
  logic [NB-1:0]     r_write_reg;
  logic [len_wb_bus-1:0] r_wb;
  logic [len-1:0]    r_debug;
  logic              r_mis_err;
  logic [len-1:0]    r_mis_addr;

  logic              w_beq, w_bne, w_rd, w_wr, w_uns;
  logic [1:0]        w_size, w_off;
  logic              w_is_byte, w_is_half, w_is_word;
  logic              w_misalign, w_store;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_be;
  logic [len-1:0]    w_wdata;
  logic [len-1:0]    w_shift;
  logic [15:0]       w_half;
  logic              w_unused;

  assign w_beq  = memory_bus[0];
  assign w_bne  = memory_bus[1];
  assign w_rd   = memory_bus[2];
  assign w_wr   = memory_bus[3];
  assign w_size = memory_bus[5:4];
  assign w_uns  = memory_bus[6];
  assign w_idx  = in_alu[ADDR_W+1:2];
  assign w_off  = in_alu[1:0];
  assign w_unused = ^{memory_bus[8:7], in_alu[len-1:ADDR_W+2]};

  assign w_is_byte = (w_size == 2'b00);
  assign w_is_half = (w_size == 2'b01);
  assign w_is_word = ~w_is_byte & ~w_is_half;

  assign w_misalign = (w_rd | w_wr) &
                      ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));
  assign w_store    = ~reset & enable & w_wr & ~w_misalign;

  assign out_pc_src    = (w_beq & in_zero_flag) | (w_bne & ~in_zero_flag);
  assign out_pc_branch = in_pc_branch;

  // Replicate store data across lanes so the byte-enable alone selects the target lanes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = in_reg2;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{in_reg2[7:0]}};
    end else if (w_is_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{in_reg2[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_debug <= '0;
    else       r_debug <= r_mem[debug_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_word   <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_alu       <= '0;
      r_write_reg <= '0;
      r_wb        <= '0;
      r_mis_err   <= 1'b0;
      r_mis_addr  <= '0;
    end else if (enable) begin
      r_rd_word   <= r_mem[w_idx];
      r_off       <= w_off;
      r_size      <= w_size;
      r_unsigned  <= w_uns;
      r_rd_en     <= w_rd & ~w_misalign;
      r_alu       <= in_alu;
      r_write_reg <= in_write_reg;
      r_wb        <= writeBack_bus;
      if (w_misalign) begin
        r_mis_err <= 1'b1;
        if (!r_mis_err) r_mis_addr <= in_alu;
      end
    end
  end

  assign w_shift = r_rd_word >> {r_off, 3'b000};
  assign w_half  = r_off[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  always_comb begin
    out_read_data = '0;
    if (r_rd_en) begin
      case (r_size)
        2'b00:   out_read_data = {{(len-8){~r_unsigned & w_shift[7]}}, w_shift[7:0]};
        2'b01:   out_read_data = {{(len-16){~r_unsigned & w_half[15]}}, w_half};
        default: out_read_data = r_rd_word;
      endcase
    end
  end

  assign out_alu           = r_alu;
  assign out_write_reg     = r_write_reg;
  assign writeBack_bus_out = r_wb;
  assign debug_data        = r_debug;
  assign misalign_error    = r_mis_err;
  assign misalign_addr     = r_mis_addr;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - scoreboard bench for the MEM stage.
module tb_memory_access;

  localparam logic [8:0] NOP = 9'h000, BEQ = 9'h001, BNE = 9'h002;
  localparam logic [8:0] SB  = 9'h008, SH  = 9'h018, SW  = 9'h038;
  localparam logic [8:0] LB  = 9'h004, LBU = 9'h044, LH  = 9'h014, LHU = 9'h054, LW = 9'h034;

  logic        clk = 0;
  logic        reset, enable, in_zero_flag;
  logic [31:0] in_pc_branch, in_alu, in_reg2;
  logic [4:0]  in_write_reg;
  logic [8:0]  memory_bus;
  logic [1:0]  writeBack_bus;
  logic [9:0]  debug_addr;
  logic        out_pc_src, misalign_error;
  logic [31:0] out_pc_branch, out_read_data, out_alu, debug_data, misalign_addr;
  logic [4:0]  out_write_reg;
  logic [1:0]  writeBack_bus_out;

  memory_access dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_pc_branch(in_pc_branch), .in_alu(in_alu), .in_zero_flag(in_zero_flag),
    .in_reg2(in_reg2), .in_write_reg(in_write_reg), .memory_bus(memory_bus),
    .writeBack_bus(writeBack_bus), .debug_addr(debug_addr),
    .out_pc_src(out_pc_src), .out_pc_branch(out_pc_branch), .out_read_data(out_read_data),
    .out_alu(out_alu), .out_write_reg(out_write_reg), .writeBack_bus_out(writeBack_bus_out),
    .debug_data(debug_data), .misalign_error(misalign_error), .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd, alu, dbg, maddr;
    logic [4:0]  wr;
    logic [1:0]  wb;
    logic        merr, cdbg;
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0, n_tot = 0;
  logic        issued = 0, tb_vld = 0;
  logic [31:0] last_alu = 0;
  logic [4:0]  last_wr = 0;
  logic [1:0]  last_wb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  always @(posedge clk) tb_vld <= issued;

  always @(negedge clk) begin
    if (tb_vld) begin
      if (q.size() == 0) begin
        chk("queue_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("read_data", out_read_data, e.rd);
        chk("alu", out_alu, e.alu);
        chk("write_reg", {27'd0, out_write_reg}, {27'd0, e.wr});
        chk("wb_bus", {30'd0, writeBack_bus_out}, {30'd0, e.wb});
        chk("misalign_error", {31'd0, misalign_error}, {31'd0, e.merr});
        chk("misalign_addr", misalign_addr, e.maddr);
        if (e.cdbg) chk("debug_data", debug_data, e.dbg);
      end
    end
  end

  task automatic op(input logic rst, input logic en, input logic [8:0] mb, input logic zf,
                    input logic [31:0] pcb, input logic [31:0] alu, input logic [31:0] r2,
                    input logic [4:0] wr, input logic [1:0] wb, input logic [9:0] dbga,
                    input logic src, input logic [31:0] rd, input logic merr,
                    input logic [31:0] maddr, input logic cdbg, input logic [31:0] dbgv);
    exp_t e;
    @(posedge clk); #1;
    reset = rst; enable = en; memory_bus = mb; in_zero_flag = zf; in_pc_branch = pcb;
    in_alu = alu; in_reg2 = r2; in_write_reg = wr; writeBack_bus = wb; debug_addr = dbga;
    issued = 1;
    e.rd = rd; e.merr = merr; e.maddr = maddr; e.cdbg = cdbg; e.dbg = dbgv;
    if (rst) begin
      e.alu = 0; e.wr = 0; e.wb = 0;
    end else if (!en) begin
      e.alu = last_alu; e.wr = last_wr; e.wb = last_wb;
    end else begin
      e.alu = alu; e.wr = wr; e.wb = wb;
    end
    last_alu = e.alu; last_wr = e.wr; last_wb = e.wb;
    q.push_back(e);
    #1;
    chk("pc_src", {31'd0, out_pc_src}, {31'd0, src});
    chk("pc_branch", out_pc_branch, pcb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1; enable = 1; memory_bus = NOP; in_zero_flag = 0; in_pc_branch = 0;
    in_alu = 0; in_reg2 = 0; in_write_reg = 0; writeBack_bus = 0; debug_addr = 0;
    repeat (2) @(posedge clk);
    //  rst en  bus  zf pcb        alu    r2            wr  wb    dbga   src rd            merr maddr  cdbg dbg
    op(1, 1, NOP, 0, 32'h100, 32'h55, 32'h0,        5'd3, 2'b11, 10'd0, 0, 32'h0,        0, 32'h0,  1, 32'h0);
    op(0, 1, SW,  0, 32'h104, 32'h10, 32'hDEADBEEF, 5'd1, 2'b00, 10'd0, 0, 32'h0,        0, 32'h0,  0, 32'h0);
    op(0, 1, LW,  0, 32'h108, 32'h10, 32'h0,        5'd2, 2'b11, 10'd4, 0, 32'hDEADBEEF, 0, 32'h0,  1, 32'hDEADBEEF);
    op(0, 1, LB,  0, 32'h10C, 32'h13, 32'h0,        5'd3, 2'b01, 10'd4, 0, 32'hFFFFFFDE, 0, 32'h0,  1, 32'hDEADBEEF);
    op(0, 1, LBU, 0, 32'h110, 32'h13, 32'h0,        5'd4, 2'b11, 10'd4, 0, 32'h000000DE, 0, 32'h0,  1, 32'hDEADBEEF);
    op(0, 1, LH,  0, 32'h114, 32'h12, 32'h0,        5'd5, 2'b11, 10'd4, 0, 32'hFFFFDEAD, 0, 32'h0,  1, 32'hDEADBEEF);
    op(0, 1, LHU, 0, 32'h118, 32'h10, 32'h0,        5'd6, 2'b11, 10'd4, 0, 32'h0000BEEF, 0, 32'h0,  1, 32'hDEADBEEF);
    op(0, 1, SB,  0, 32'h11C, 32'h11, 32'h0000AB55, 5'd0, 2'b00, 10'd4, 0, 32'h0,        0, 32'h0,  1, 32'hDEADBEEF);
    op(0, 1, LW,  0, 32'h120, 32'h10, 32'h0,        5'd7, 2'b11, 10'd4, 0, 32'hDEAD55EF, 0, 32'h0,  1, 32'hDEAD55EF);
    op(0, 1, SH,  0, 32'h124, 32'h12, 32'hCAFE1234, 5'd0, 2'b00, 10'd4, 0, 32'h0,        0, 32'h0,  1, 32'hDEAD55EF);
    op(0, 1, LW,  0, 32'h128, 32'h10, 32'h0,        5'd8, 2'b11, 10'd4, 0, 32'h123455EF, 0, 32'h0,  1, 32'h123455EF);
    op(0, 1, LB,  0, 32'h12C, 32'h10, 32'h0,        5'd9, 2'b11, 10'd4, 0, 32'hFFFFFFEF, 0, 32'h0,  1, 32'h123455EF);
    op(0, 1, LH,  0, 32'h130, 32'h12, 32'h0,        5'd10, 2'b11, 10'd4, 0, 32'h00001234, 0, 32'h0, 1, 32'h123455EF);
    op(0, 1, SW,  0, 32'h134, 32'h20, 32'h11223344, 5'd0, 2'b00, 10'd8, 0, 32'h0,        0, 32'h0,  0, 32'h0);
    op(0, 1, SW,  0, 32'h138, 32'h21, 32'hFFFFFFFF, 5'd0, 2'b00, 10'd8, 0, 32'h0,        1, 32'h21, 1, 32'h11223344);
    op(0, 1, LW,  0, 32'h13C, 32'h20, 32'h0,        5'd11, 2'b11, 10'd8, 0, 32'h11223344, 1, 32'h21, 1, 32'h11223344);
    op(0, 1, LH,  0, 32'h140, 32'h33, 32'h0,        5'd12, 2'b11, 10'd8, 0, 32'h0,       1, 32'h21, 1, 32'h11223344);
    op(0, 1, LW,  0, 32'h144, 32'h22, 32'h0,        5'd13, 2'b11, 10'd8, 0, 32'h0,       1, 32'h21, 1, 32'h11223344);
    op(0, 1, BEQ, 1, 32'h400, 32'h0,  32'h0,        5'd0, 2'b00, 10'd8, 1, 32'h0,        1, 32'h21, 1, 32'h11223344);
    op(0, 1, BEQ, 0, 32'h404, 32'h1,  32'h0,        5'd0, 2'b00, 10'd8, 0, 32'h0,        1, 32'h21, 1, 32'h11223344);
    op(0, 1, BNE, 0, 32'h408, 32'h1,  32'h0,        5'd0, 2'b00, 10'd8, 1, 32'h0,        1, 32'h21, 1, 32'h11223344);
    op(0, 1, BNE, 1, 32'h40C, 32'h0,  32'h0,        5'd0, 2'b00, 10'd8, 0, 32'h0,        1, 32'h21, 1, 32'h11223344);
    op(0, 1, SW,  0, 32'h150, 32'h40, 32'hA5A5A5A5, 5'd0, 2'b00, 10'h10, 0, 32'h0,       1, 32'h21, 0, 32'h0);
    op(0, 1, LW,  0, 32'h154, 32'h40, 32'h0,        5'd7, 2'b11, 10'h10, 0, 32'hA5A5A5A5, 1, 32'h21, 1, 32'hA5A5A5A5);
    op(0, 0, SW,  0, 32'h158, 32'h40, 32'h00000001, 5'd9, 2'b00, 10'h10, 0, 32'hA5A5A5A5, 1, 32'h21, 1, 32'hA5A5A5A5);
    op(0, 1, LW,  0, 32'h15C, 32'h40, 32'h0,        5'd14, 2'b01, 10'h10, 0, 32'hA5A5A5A5, 1, 32'h21, 1, 32'hA5A5A5A5);
    op(0, 1, SW,  0, 32'h160, 32'h44, 32'h77777777, 5'd0, 2'b00, 10'h11, 0, 32'h0,       1, 32'h21, 0, 32'h0);
    op(1, 1, SW,  0, 32'h164, 32'h44, 32'hBBBBBBBB, 5'd15, 2'b11, 10'h11, 0, 32'h0,      0, 32'h0,  1, 32'h0);
    op(0, 1, LW,  0, 32'h168, 32'h44, 32'h0,        5'd16, 2'b11, 10'h11, 0, 32'h77777777, 0, 32'h0, 1, 32'h77777777);
    op(0, 1, LW,  0, 32'h16C, 32'h10, 32'h0,        5'd17, 2'b11, 10'd4, 0, 32'h123455EF, 0, 32'h0,  1, 32'h123455EF);
    op(0, 1, SH,  0, 32'h170, 32'h45, 32'h0000FFFF, 5'd0, 2'b00, 10'h11, 0, 32'h0,       1, 32'h45, 1, 32'h77777777);
    @(posedge clk); #1;
    issued = 0; memory_bus = NOP;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
